serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single full-adder cell plus a carry flip-flop.
- Loads two operands and a carry-in, then adds one bit per clock, LSB first.
- After WIDTH clocks it presents the full sum and carry-out.
- It is the sequential consumer of the team's 1-bit full adder. Area-cheap alternative to a ripple-carry adder for multi-cycle datapaths.

Parameters:
WIDTH, 8, operand/sum width in bits (>=2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled on rising clk when idle (IDLE or DONE state)
a  input  WIDTH  operand A, sampled with accepted start
b  input  WIDTH  operand B, sampled with accepted start
cin  input  1  carry-in, sampled with accepted start
busy  output  1  high while additions in progress (SHIFT state)
done  output  1  one-cycle pulse: sum/cout just became valid
sum  output  WIDTH  result, registered, held until next result
cout  output  1  final carry-out, registered, held until next result

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). Reset has priority over all other inputs.
- Reset values:
  - state = IDLE; busy = 0, done = 0, sum = 0, cout = 0.
  - Internal operand shift registers, carry flip-flop and bit counter are all 0.
- States: IDLE, SHIFT, DONE. Moore outputs:
  - busy = (state == SHIFT)
  - done = (state == DONE)
- IDLE:
  - start = 1: load a -> opA, b -> opB, cin -> carry, counter <= 0, sum accumulator <= 0; next state SHIFT.
  - start = 0: stay in IDLE.
- SHIFT, on each clock:
  - s = opA[0] ^ opB[0] ^ carry.
  - carry <= (opA[0]&opB[0]) | (opA[0]&carry) | (opB[0]&carry).
  - opA, opB shift right by 1 (zero fill).
  - Accumulator shifts right with s inserted at MSB.
  - counter += 1.
- Exit from SHIFT:
  - On the clock where counter == WIDTH-1, the final bit is processed.
  - Same edge: sum <= completed accumulator, cout <= final carry, next state DONE.
- DONE: lasts exactly one cycle. Next state is SHIFT if start = 1 (new operands loaded exactly as in IDLE), else IDLE.
- Latency:
  - Start sampled at edge k -> busy high in cycles k+1 .. k+WIDTH.
  - done high for the cycle after edge k+WIDTH.
  - Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- Output stability:
  - sum/cout change only on the edge entering DONE (or on reset).
  - Held through IDLE and through the following SHIFT sequence.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- start while busy = 1 is ignored: no reload, no effect on the result.
- a, b, cin are don't-care except on the accepting edge. Later changes must not affect the result.
- rst asserted mid-SHIFT:
  - Operation aborted; next cycle all outputs at reset values; no done pulse.
  - A start on the first edge after rst deasserts is accepted normally.
- Counter width: clog2(WIDTH) bits; no wrap-around beyond WIDTH-1 within an operation.

Test Plan:
- Basic add, WIDTH=8: a=0x5A, b=0x3C, cin=0, start pulsed -> busy for 8 cycles; done pulse one cycle later; sum=0x96, cout=0.
- Full carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Protocol: during SHIFT, pulse start with a=0x11, b=0x22 and change a/b/cin every cycle -> ignored. The original result is unchanged; busy is not extended.
- Back-to-back: hold start=1 with new operands (0x80+0x80, cin=0) during the DONE cycle -> busy again the next cycle. Second done exactly 9 cycles after the first, with sum=0x00, cout=1. The first result is held until then.
- Reset mid-operation: assert rst after 3 SHIFT cycles -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse. A following start of 0x01+0x02 gives sum=0x03.
- Exhaustive, WIDTH=3: all 128 combinations of {cin,b,a} -> {cout,sum} == a+b+cin each time. Checks cover done-pulse width (1 cycle) and latency (done 3 cycles after the start-sampling edge).

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle between a requester and the bit-serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: one full-adder cell plus carry flop, adds WIDTH-bit operands LSB first.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] op_a, op_b, acc, sum_r;
    logic [CW-1:0]    cnt;
    logic             carry, cout_r, s, carry_nx, load, last;

    always_comb begin
        s        = op_a[0] ^ op_b[0] ^ carry;
        carry_nx = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        last     = cnt == CW'(WIDTH - 1);
        load     = state != SHIFT && bus.start;
        state_nx = state == SHIFT ? (last ? DONE : SHIFT) : (bus.start ? SHIFT : IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                op_a  <= bus.a;
                op_b  <= bus.b;
                carry <= bus.cin;
                cnt   <= '0;
                acc   <= '0;
            end else if (state == SHIFT) begin
                op_a  <= op_a >> 1;
                op_b  <= op_b >> 1;
                carry <= carry_nx;
                acc   <= {s, acc[WIDTH-1:1]};
                cnt   <= cnt + 1'b1;
                // Publish on the final bit so sum/cout stay frozen during the next operation
                if (last) begin
                    sum_r  <= {s, acc[WIDTH-1:1]};
                    cout_r <= carry_nx;
                end
            end
        end
    end

    assign bus.busy = state == SHIFT;
    assign bus.done = state == DONE;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed + random checks of serial_adder at WIDTH=8 and exhaustive WIDTH=3.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [7:0] held_sum = '0;
    logic       held_cout = 1'b0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) i8 ();
    serial_adder_if #(.WIDTH(3)) i3 ();

    serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(i8));
    serial_adder #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .bus(i3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with the DUT idle or in DONE.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
        i8.start = 1'b1;
        i8.a     = a;
        i8.b     = b;
        i8.cin   = c;
        @(negedge clk);
        i8.start = 1'b0;
    endtask

    // Follows an accepted operation through busy to the done cycle; noisy drives junk inputs.
    task automatic track8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit noisy);
        int r;
        r = int'(a) + int'(b) + int'(c);
        for (int i = 0; i < 8; i++) begin
            chk("busy8", i8.busy, 1);
            chk("nodone8", i8.done, 0);
            chk("held8", {i8.cout, i8.sum}, {held_cout, held_sum});
            if (noisy) begin
                i8.start = (i == 2 || i == 7);
                i8.a     = (i == 2) ? 8'h11 : 8'($urandom);
                i8.b     = (i == 2) ? 8'h22 : 8'($urandom);
                i8.cin   = 1'($urandom);
            end
            @(negedge clk);
            i8.start = 1'b0;
        end
        held_sum  = r[7:0];
        held_cout = r[8];
        chk("done8", i8.done, 1);
        chk("dbusy8", i8.busy, 0);
        chk("sum8", {i8.cout, i8.sum}, {held_cout, held_sum});
    endtask

    task automatic idle8();
        @(negedge clk);
        chk("pulse8", i8.done, 0);
        chk("idle8", i8.busy, 0);
        chk("keep8", {i8.cout, i8.sum}, {held_cout, held_sum});
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        int         r;
        i8.start = 0; i8.a = '0; i8.b = '0; i8.cin = 0;
        i3.start = 0; i3.a = '0; i3.b = '0; i3.cin = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", i8.busy, 0);
        chk("rst_done", i8.done, 0);
        chk("rst_res", {i8.cout, i8.sum}, 0);
        chk("rst_res3", {i3.busy, i3.done, i3.cout, i3.sum}, 0);
        rst = 1'b0;

        go8(8'h5A, 8'h3C, 0); track8(8'h5A, 8'h3C, 0, 0); idle8();
        go8(8'hFF, 8'h01, 0); track8(8'hFF, 8'h01, 0, 0); idle8();
        go8(8'hFF, 8'hFF, 1); track8(8'hFF, 8'hFF, 1, 0); idle8();
        go8(8'h00, 8'h00, 1); track8(8'h00, 8'h00, 1, 0); idle8();

        go8(8'h5A, 8'h3C, 1); track8(8'h5A, 8'h3C, 1, 1); idle8();

        go8(8'h12, 8'h34, 0); track8(8'h12, 8'h34, 0, 0);
        go8(8'h80, 8'h80, 0); track8(8'h80, 8'h80, 0, 0); idle8();

        go8(8'hA5, 8'h5B, 0);
        repeat (3) begin
            chk("rbusy", i8.busy, 1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort", {i8.busy, i8.done, i8.cout, i8.sum}, 0);
        rst = 1'b0;
        held_sum = '0; held_cout = 1'b0;
        go8(8'h01, 8'h02, 0); track8(8'h01, 8'h02, 0, 0); idle8();

        repeat (20) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            go8(ra, rb, rc); track8(ra, rb, rc, 0); idle8();
        end

        for (int i = 0; i < 128; i++) begin
            r = int'(i[2:0]) + int'(i[5:3]) + int'(i[6]);
            i3.start = 1'b1; i3.a = i[2:0]; i3.b = i[5:3]; i3.cin = i[6];
            @(negedge clk);
            i3.start = 1'b0;
            i3.a = 3'($urandom); i3.b = 3'($urandom); i3.cin = 1'($urandom);
            repeat (3) begin
                chk("busy3", {i3.busy, i3.done}, 2'b10);
                @(negedge clk);
            end
            chk("done3", {i3.busy, i3.done}, 2'b01);
            chk("sum3", {i3.cout, i3.sum}, r[3:0]);
            @(negedge clk);
            chk("pulse3", {i3.busy, i3.done}, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
